// File: rtl/decode_rr_arbiter.sv
// Round-robin arbiter feeding a variable decoder. It picks one requester
// and presents its binary index and the matching registered one-hot grant.
// Each grant is held until done, request withdrawal or the hold limit.
// One dead cycle always separates successive owners.
module decode_rr_arbiter #(
    parameter int unsigned IDX_W    = 4,
    parameter int unsigned MAX_HOLD = 255,
    parameter int unsigned HOLD_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [(2**IDX_W)-1:0]   req_in,
    input  logic                    done_in,
    output logic [IDX_W-1:0]        grant_idx_out,
    output logic [(2**IDX_W)-1:0]   grant_out,
    output logic                    grant_vld_out,
    output logic                    timeout_out
);

    localparam int unsigned N_REQ = 2 ** IDX_W;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  idx;
    logic [HOLD_W-1:0] hcnt;

    logic [IDX_W-1:0]  pick_idx;
    logic              pick_vld;
    logic [IDX_W-1:0]  cand;
    logic              hold_limit;
    logic              release_now;

    // First set request at or above ptr, wrapping through the top index
    always_comb begin
        pick_idx = '0;
        pick_vld = 1'b0;
        cand     = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = ptr + IDX_W'(i);
            if (!pick_vld && req_in[cand]) begin
                pick_idx = cand;
                pick_vld = 1'b1;
            end
        end
    end

    // Release causes of the current owner
    always_comb begin
        hold_limit  = (hcnt == HOLD_W'(MAX_HOLD - 1));
        release_now = done_in || !req_in[idx] || hold_limit;
    end

    assign grant_idx_out = idx;

    // Arbitration FSM with registered grant outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            ptr           <= '0;
            idx           <= '0;
            hcnt          <= '0;
            grant_vld_out <= 1'b0;
            grant_out     <= '0;
            timeout_out   <= 1'b0;
        end else begin
            timeout_out <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        idx           <= pick_idx;
                        hcnt          <= '0;
                        grant_vld_out <= 1'b1;
                        grant_out     <= N_REQ'(1) << pick_idx;
                        state         <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    hcnt <= hcnt + HOLD_W'(1);
                    if (release_now) begin
                        // Done or withdrawal outranks the hold limit
                        timeout_out   <= !done_in && req_in[idx];
                        ptr           <= idx + IDX_W'(1);
                        grant_vld_out <= 1'b0;
                        grant_out     <= '0;
                        state         <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state         <= S_IDLE;
                    grant_vld_out <= 1'b0;
                    grant_out     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decode_rr_arbiter.sv
// Bench for decode_rr_arbiter: directed scenarios with literal expectations
// plus a cycle-level behavioural model compared on every falling edge.
module tb_decode_rr_arbiter;

    localparam int unsigned IDX_W    = 4;
    localparam int unsigned N_REQ    = 16;
    localparam int unsigned MAX_HOLD = 8;
    localparam int unsigned HOLD_W   = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N_REQ-1:0]  req_in = '0;
    logic              done_in = 1'b0;
    logic [IDX_W-1:0]  grant_idx_out;
    logic [N_REQ-1:0]  grant_out;
    logic              grant_vld_out;
    logic              timeout_out;

    int vectors = 0;
    int errors  = 0;

    decode_rr_arbiter #(
        .IDX_W    (IDX_W),
        .MAX_HOLD (MAX_HOLD),
        .HOLD_W   (HOLD_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_in        (req_in),
        .done_in       (done_in),
        .grant_idx_out (grant_idx_out),
        .grant_out     (grant_out),
        .grant_vld_out (grant_vld_out),
        .timeout_out   (timeout_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: owner, who-is-next, cycles held, one dead cycle
    bit       m_vld  = 1'b0;
    int       m_idx  = 0;
    int       m_ptr  = 0;
    int       m_held = 0;
    bit       m_dead = 1'b0;
    bit       m_to   = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_vld = 1'b0; m_idx = 0; m_ptr = 0; m_held = 0; m_dead = 1'b0; m_to = 1'b0;
        end else begin
            m_to = 1'b0;
            if (m_vld) begin
                m_held = m_held + 1;
                if (done_in || !req_in[m_idx] || m_held == MAX_HOLD) begin
                    m_to   = !done_in && req_in[m_idx];
                    m_vld  = 1'b0;
                    m_ptr  = (m_idx + 1) % N_REQ;
                    m_dead = 1'b1;
                end
            end else if (m_dead) begin
                m_dead = 1'b0;
            end else if (req_in != '0) begin
                for (int k = 0; k < N_REQ; k++) begin
                    if (!m_vld && req_in[(m_ptr + k) % N_REQ]) begin
                        m_idx  = (m_ptr + k) % N_REQ;
                        m_vld  = 1'b1;
                        m_held = 0;
                    end
                end
            end
        end
    end

    // Compare DUT to model away from the active edge
    always @(negedge clk) begin
        logic [N_REQ-1:0] exp_gnt;
        exp_gnt = m_vld ? (N_REQ'(1) << m_idx) : '0;
        check("model_vld", 32'(grant_vld_out), 32'(m_vld));
        check("model_idx", 32'(grant_idx_out), 32'(m_idx));
        check("model_gnt", 32'(grant_out), 32'(exp_gnt));
        check("model_timeout", 32'(timeout_out), 32'(m_to));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_grant(output int g);
        int n;
        n = 0;
        while (!grant_vld_out && n < 20) begin
            tick();
            n++;
        end
        if (!grant_vld_out) check("grant_wait_expired", 32'(0), 32'(1));
        g = int'(grant_idx_out);
    endtask

    initial begin
        int g;
        int cnt;
        int seq [4];
        seq = '{15, 0, 15, 0};

        // Reset with every request asserted
        req_in = 16'hFFFF;
        tick(); tick();
        check("rst_vld", 32'(grant_vld_out), 32'(0));
        check("rst_gnt", 32'(grant_out), 32'(0));
        check("rst_idx", 32'(grant_idx_out), 32'(0));
        check("rst_to", 32'(timeout_out), 32'(0));
        rst_n = 1'b1;
        tick();
        check("first_idx", 32'(grant_idx_out), 32'(0));
        check("first_gnt", 32'(grant_out), 32'h0001);
        check("first_vld", 32'(grant_vld_out), 32'(1));
        req_in = '0;
        tick();
        check("withdraw_vld", 32'(grant_vld_out), 32'(0));
        tick();

        // Single requester, done, regrant two cycles after release
        req_in = 16'h0020;
        tick();
        check("single_idx", 32'(grant_idx_out), 32'(5));
        check("single_gnt", 32'(grant_out), 32'h0020);
        check("single_vld", 32'(grant_vld_out), 32'(1));
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        check("done_vld", 32'(grant_vld_out), 32'(0));
        tick();
        check("dead_vld", 32'(grant_vld_out), 32'(0));
        tick();
        check("regrant_vld", 32'(grant_vld_out), 32'(1));
        check("regrant_idx", 32'(grant_idx_out), 32'(5));

        // Round robin wrap between 15 and 0
        req_in = 16'h8001;
        tick();
        check("rr_drop_vld", 32'(grant_vld_out), 32'(0));
        for (int i = 0; i < 4; i++) begin
            wait_grant(g);
            check("rr_seq", 32'(g), 32'(seq[i]));
            done_in = 1'b1;
            tick();
            done_in = 1'b0;
            check("rr_gap", 32'(grant_vld_out), 32'(0));
        end

        // Hold limit: owner 3 then 0, with a single timeout pulse
        req_in = 16'h0009;
        wait_grant(g);
        check("to_first_idx", 32'(g), 32'(3));
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (!grant_vld_out) break;
            cnt++;
            tick();
        end
        check("to_len", 32'(cnt), 32'(MAX_HOLD));
        check("to_pulse", 32'(timeout_out), 32'(1));
        tick();
        check("to_pulse_end", 32'(timeout_out), 32'(0));
        wait_grant(g);
        check("to_next_idx", 32'(g), 32'(0));

        // Done on the last allowed cycle: no timeout
        repeat (7) tick();
        check("sim_still_vld", 32'(grant_vld_out), 32'(1));
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        check("sim_done_vld", 32'(grant_vld_out), 32'(0));
        check("sim_done_to", 32'(timeout_out), 32'(0));

        // Withdrawal mid-grant: no timeout
        wait_grant(g);
        check("wd_idx", 32'(g), 32'(3));
        tick(); tick();
        req_in = 16'h0001;
        tick();
        check("wd_vld", 32'(grant_vld_out), 32'(0));
        check("wd_to", 32'(timeout_out), 32'(0));

        // Asynchronous reset while requester 7 owns the grant
        req_in = 16'h0080;
        wait_grant(g);
        check("ar_idx", 32'(g), 32'(7));
        #1 rst_n = 1'b0;
        #1;
        check("ar_vld", 32'(grant_vld_out), 32'(0));
        check("ar_gnt", 32'(grant_out), 32'(0));
        check("ar_idx0", 32'(grant_idx_out), 32'(0));
        req_in = 16'h0081;
        tick();
        rst_n = 1'b1;
        wait_grant(g);
        check("ar_restart_idx", 32'(g), 32'(0));
        check("ar_restart_gnt", 32'(grant_out), 32'h0001);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
